// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: channel state encoding and
// the prescaler default that the PWM generator also uses.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } ch_state_e;

    localparam int unsigned PRESC_W          = 14;
    localparam int unsigned DEFAULT_PRESCALE = 3750;

endpackage

// File: rtl/pwm_capture_ch.sv
// Single capture channel: input synchronizer, edge detect, measurement FSM,
// tick counters and registered result fields.
module pwm_capture_ch
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             pwm,
    input  logic             clear,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             upd
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1_r, sync2_r, sync3_r;
    logic             rise_s, fall_s, timeout_s;
    ch_state_e        state_r, state_nxt_s;
    logic [CNT_W-1:0] hcnt_r, hcnt_nxt_s;
    logic [CNT_W-1:0] pcnt_r, pcnt_nxt_s;
    logic [CNT_W-1:0] duty_r, duty_nxt_s;
    logic [CNT_W-1:0] period_r, period_nxt_s;
    logic             valid_r, valid_nxt_s;
    logic             upd_r, upd_nxt_s;

    // Two-flop synchronizer plus a history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= pwm;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign rise_s    = sync2_r & ~sync3_r;
    assign fall_s    = ~sync2_r & sync3_r;
    // Period counter saturated and another tick arrives: the line is dead.
    assign timeout_s = tick && (pcnt_r == CNT_MAX);

    // Next-state, counter and result logic; clear beats any same-cycle publish.
    always_comb begin
        state_nxt_s  = state_r;
        hcnt_nxt_s   = hcnt_r;
        pcnt_nxt_s   = pcnt_r;
        duty_nxt_s   = duty_r;
        period_nxt_s = period_r;
        valid_nxt_s  = valid_r;
        upd_nxt_s    = 1'b0;

        if (clear || (timeout_s && (state_r != ST_IDLE) && !(state_r == ST_LOW && rise_s))) begin
            state_nxt_s  = ST_IDLE;
            hcnt_nxt_s   = '0;
            pcnt_nxt_s   = '0;
            duty_nxt_s   = '0;
            period_nxt_s = '0;
            valid_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    hcnt_nxt_s = '0;
                    pcnt_nxt_s = '0;
                    if (rise_s) begin
                        state_nxt_s = ST_HIGH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        hcnt_nxt_s = hcnt_r + CNT_W'(1);
                        pcnt_nxt_s = pcnt_r + CNT_W'(1);
                    end else begin
                        hcnt_nxt_s = hcnt_r;
                        pcnt_nxt_s = pcnt_r;
                    end
                    if (fall_s) begin
                        state_nxt_s = ST_LOW;
                    end else begin
                        state_nxt_s = ST_HIGH;
                    end
                end
                ST_LOW: begin
                    if (rise_s) begin
                        duty_nxt_s   = hcnt_r;
                        period_nxt_s = pcnt_r;
                        valid_nxt_s  = 1'b1;
                        upd_nxt_s    = 1'b1;
                        hcnt_nxt_s   = '0;
                        pcnt_nxt_s   = '0;
                        state_nxt_s  = ST_HIGH;
                    end else if (tick) begin
                        pcnt_nxt_s = pcnt_r + CNT_W'(1);
                    end else begin
                        pcnt_nxt_s = pcnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    hcnt_nxt_s  = '0;
                    pcnt_nxt_s  = '0;
                end
            endcase
        end
    end

    // Channel state, counters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            hcnt_r   <= '0;
            pcnt_r   <= '0;
            duty_r   <= '0;
            period_r <= '0;
            valid_r  <= 1'b0;
            upd_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            hcnt_r   <= hcnt_nxt_s;
            pcnt_r   <= pcnt_nxt_s;
            duty_r   <= duty_nxt_s;
            period_r <= period_nxt_s;
            valid_r  <= valid_nxt_s;
            upd_r    <= upd_nxt_s;
        end
    end

    assign duty   = duty_r;
    assign period = period_r;
    assign valid  = valid_r;
    assign upd    = upd_r;

endmodule

// File: rtl/pwm_capture.sv
// Multi-channel PWM input decoder: shared tick prescaler feeding N_CH
// independent high-time / period capture channels.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned CNT_W    = 9,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_CH-1:0]       pwm_i,
    input  logic [N_CH-1:0]       clear_i,
    output logic [N_CH*CNT_W-1:0] duty_o,
    output logic [N_CH*CNT_W-1:0] period_o,
    output logic [N_CH-1:0]       valid_o,
    output logic [N_CH-1:0]       upd_o
);

    logic [PRESC_W-1:0] presc_r;
    logic               tick_s;

    assign tick_s = (presc_r == PRESC_W'(PRESCALE));

    // Prescaler: one tick every PRESCALE+1 clocks, same phase rule as the generator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRESC_W'(1);
        end
    end

    for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
        pwm_capture_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk    (clk_i),
            .rst_n  (rst_ni),
            .tick   (tick_s),
            .pwm    (pwm_i[k]),
            .clear  (clear_i[k]),
            .duty   (duty_o[k*CNT_W +: CNT_W]),
            .period (period_o[k*CNT_W +: CNT_W]),
            .valid  (valid_o[k]),
            .upd    (upd_o[k])
        );
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture at PRESCALE=3 (one tick every 4 clocks).
module tb_pwm_capture;

    localparam int N_CH     = 8;
    localparam int CNT_W    = 9;
    localparam int PRESCALE = 3;

    logic                  clk = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [N_CH-1:0]       pwm_i = '0;
    logic [N_CH-1:0]       clear_i = '0;
    logic [N_CH*CNT_W-1:0] duty_o;
    logic [N_CH*CNT_W-1:0] period_o;
    logic [N_CH-1:0]       valid_o;
    logic [N_CH-1:0]       upd_o;

    int n_chk = 0;
    int n_pass = 0;
    int cyc;
    int upd_cnt [N_CH];
    int snap [N_CH];
    int high [N_CH] = '{8, 20, 32, 40, 52, 60, 72, 88};

    pwm_capture #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .pwm_i    (pwm_i),
        .clear_i  (clear_i),
        .duty_o   (duty_o),
        .period_o (period_o),
        .valid_o  (valid_o),
        .upd_o    (upd_o)
    );

    always #5 clk = ~clk;

    // Edge index since reset release; a tick is consumed at edges with cyc%4==0.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Count upd pulses per channel, sampled away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < N_CH; k++)
            if (upd_o[k]) upd_cnt[k] <= upd_cnt[k] + 1;
    end

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic logic [CNT_W-1:0] duty_of(input int k);
        return duty_o[k*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] period_of(input int k);
        return period_o[k*CNT_W +: CNT_W];
    endfunction

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align(input int p);
        adv(1);
        while ((cyc % 4) != p) adv(1);
    endtask

    task automatic take_snap();
        for (int k = 0; k < N_CH; k++) snap[k] = upd_cnt[k];
    endtask

    // Drive rise, 40 clocks high, 60 low, rise on channel ch from the current edge.
    task automatic two_rises(input int ch);
        pwm_i[ch] = 1'b1;
        adv(40);
        pwm_i[ch] = 1'b0;
        adv(60);
        pwm_i[ch] = 1'b1;
    endtask

    initial begin
        // Reset held while inputs toggle.
        for (int i = 0; i < 12; i++) begin
            adv(1);
            pwm_i = ~pwm_i;
        end
        check_eq("rst_duty", duty_o, 0);
        check_eq("rst_period", period_o, 0);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_upd", upd_o, 0);
        pwm_i = '0;
        adv(2);
        rst_ni = 1'b1;
        take_snap();
        adv(40);
        check_eq("idle_valid", valid_o, 0);
        check_eq("idle_upd", upd_o, 0);
        check_eq("idle_upd_cnt", upd_cnt[0] + upd_cnt[3] + upd_cnt[7] - snap[0] - snap[3] - snap[7], 0);

        // Nominal: 40-clock high, 100-clock period, edges away from ticks.
        align(3);
        take_snap();
        two_rises(0);
        adv(2);
        check_eq("nom_upd_early", upd_o[0], 0);
        adv(1);
        check_eq("nom_upd", upd_o[0], 1);
        check_eq("nom_duty", duty_of(0), 10);
        check_eq("nom_period", period_of(0), 25);
        check_eq("nom_valid", valid_o[0], 1);
        adv(1);
        check_eq("nom_upd_once", upd_o[0], 0);
        adv(36);
        pwm_i[0] = 1'b0;
        adv(20);
        check_eq("nom_duty_hold", duty_of(0), 10);
        check_eq("nom_period_hold", period_of(0), 25);
        check_eq("nom_upd_cnt", upd_cnt[0] - snap[0], 1);

        // Timeout: line stuck high after a valid measurement.
        align(3);
        take_snap();
        two_rises(1);
        adv(3);
        check_eq("to_valid_pre", valid_o[1], 1);
        check_eq("to_duty_pre", duty_of(1), 10);
        adv(2045);
        check_eq("to_valid_edge", valid_o[1], 1);
        adv(1);
        check_eq("to_valid", valid_o[1], 0);
        check_eq("to_duty", duty_of(1), 0);
        check_eq("to_period", period_of(1), 0);
        check_eq("to_upd_cnt", upd_cnt[1] - snap[1], 1);
        pwm_i[1] = 1'b0;
        align(3);
        two_rises(1);
        adv(3);
        check_eq("to_restore_valid", valid_o[1], 1);
        check_eq("to_restore_duty", duty_of(1), 10);
        check_eq("to_restore_period", period_of(1), 25);
        pwm_i[1] = 1'b0;

        // Rise and fall coincide with ticks; then clear in the publish cycle.
        align(1);
        take_snap();
        two_rises(2);
        adv(3);
        check_eq("sim_upd", upd_o[2], 1);
        check_eq("sim_duty", duty_of(2), 10);
        check_eq("sim_period", period_of(2), 24);
        adv(37);
        pwm_i[2] = 1'b0;
        adv(60);
        pwm_i[2] = 1'b1;
        adv(2);
        clear_i[2] = 1'b1;
        adv(1);
        clear_i[2] = 1'b0;
        check_eq("clr_valid", valid_o[2], 0);
        check_eq("clr_upd", upd_o[2], 0);
        check_eq("clr_duty", duty_of(2), 0);
        check_eq("clr_period", period_of(2), 0);
        check_eq("clr_upd_cnt", upd_cnt[2] - snap[2], 1);
        pwm_i[2] = 1'b0;

        // Reset mid-measurement takes effect immediately.
        rst_ni = 1'b0;
        #1;
        check_eq("async_rst_valid", valid_o, 0);
        check_eq("async_rst_duty", duty_o, 0);
        adv(2);
        rst_ni = 1'b1;

        // All channels, different duties, channel 5 cleared mid-run.
        align(3);
        take_snap();
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < N_CH; k++) pwm_i[k] = ((t % 100) < high[k]);
            clear_i[5] = (t == 250);
            adv(1);
        end
        clear_i = '0;
        adv(10);
        for (int k = 0; k < N_CH; k++) begin
            if (k == 5) begin
                check_eq($sformatf("ind_valid%0d", k), valid_o[k], 0);
                check_eq($sformatf("ind_duty%0d", k), duty_of(k), 0);
                check_eq($sformatf("ind_period%0d", k), period_of(k), 0);
                check_eq($sformatf("ind_upd_cnt%0d", k), upd_cnt[k] - snap[k], 2);
            end else begin
                check_eq($sformatf("ind_valid%0d", k), valid_o[k], 1);
                check_eq($sformatf("ind_duty%0d", k), duty_of(k), high[k] / 4);
                check_eq($sformatf("ind_period%0d", k), period_of(k), 25);
                check_eq($sformatf("ind_upd_cnt%0d", k), upd_cnt[k] - snap[k], 3);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
